// File: rtl/high_bus_endpoint.sv
// high_bus_endpoint: far-end endpoint of the high-width bus.
// High-width write beats inside the address window are buffered in a circular
// FIFO. A read FSM then offers the words one at a time on the read port.
// Writes that are dropped raise sticky flags: addr_reject for a beat outside
// the window, overflow for an in-window beat that arrives while the FIFO is full.
module high_bus_endpoint #(
   parameter int BRUST_SIZE_LOG = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int LOW_DATA_WIDTH = 8,
   parameter int FIFO_DEPTH_LOG = 2,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LO = '0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_HI = '1
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [LOW_DATA_WIDTH*(2**BRUST_SIZE_LOG)-1:0]     high_write_data,
   input  logic [ADDR_WIDTH-1:0]                             high_write_addr,
   input  logic                                              high_write_valid,
   output logic [LOW_DATA_WIDTH*(2**BRUST_SIZE_LOG)-1:0]     high_read_data,
   output logic                                              high_read_valid,
   input  logic                                              high_read_finish,
   output logic [FIFO_DEPTH_LOG:0]                           fifo_count,
   output logic                                              overflow,
   output logic                                              addr_reject
);

   localparam int HW = LOW_DATA_WIDTH * (2**BRUST_SIZE_LOG);
   localparam int DEPTH = 2**FIFO_DEPTH_LOG;
   localparam logic [FIFO_DEPTH_LOG:0] FULL_CNT = (FIFO_DEPTH_LOG+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t state, state_next;

   logic [HW-1:0]             mem [DEPTH];
   logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
   logic                      addr_ok;
   logic                      fifo_full;
   logic                      push;
   logic                      pop;

   // Inclusive unsigned window test, done with borrow bits so that
   // full-range defaults do not collapse into constant comparisons.
   function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH:0] d_lo;
      logic [ADDR_WIDTH:0] d_hi;
      d_lo = {1'b0, a} - {1'b0, ADDR_LO};
      d_hi = {1'b0, ADDR_HI} - {1'b0, a};
      return !d_lo[ADDR_WIDTH] && !d_hi[ADDR_WIDTH];
   endfunction

   // Push qualification. The full test uses the pre-edge count, so a pop on
   // the same edge never makes room for a write that arrives while full.
   always_comb begin
      addr_ok   = in_window(high_write_addr);
      fifo_full = (fifo_count == FULL_CNT);
      push      = high_write_valid && addr_ok && !fifo_full;
   end

   // FIFO storage. The data words need no reset; the pointers and count
   // decide what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= high_write_data;
   end

   // Pointers and occupancy. Simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Sticky drop flags. An out-of-window beat reports only addr_reject.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow    <= 1'b0;
         addr_reject <= 1'b0;
      end else begin
         if (high_write_valid && !addr_ok)
            addr_reject <= 1'b1;
         if (high_write_valid && addr_ok && fifo_full)
            overflow <= 1'b1;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Read FSM next state. GAP always lasts one cycle, so a registered
   // finish from the reader cannot consume a second word.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (fifo_count != '0) state_next = S_SEND;
         S_SEND:  if (high_read_finish) state_next = S_GAP;
         S_GAP:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Read FSM outputs. The pop happens on the IDLE->SEND edge.
   always_comb begin
      high_read_valid = (state == S_SEND);
      pop             = (state == S_IDLE) && (fifo_count != '0);
   end

   // Offered word register. It is loaded at pop and held stable through SEND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         high_read_data <= '0;
      else if (pop)
         high_read_data <= mem[rd_ptr];
   end

endmodule

// File: tb/tb_high_bus_endpoint.sv
// Directed testbench for high_bus_endpoint: a default-window instance and a
// second instance restricted to 0x0100..0x01FF.
module tb_high_bus_endpoint;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wd = '0;
   logic [15:0] wa = '0;
   logic        wv = 1'b0;
   logic        wv_w = 1'b0;
   logic        fin = 1'b0;

   logic [31:0] rd, rd_w;
   logic        rv, rv_w;
   logic [2:0]  cnt, cnt_w;
   logic        ovf, ovf_w;
   logic        arej, arej_w;

   int checks = 0;
   int passed = 0;

   high_bus_endpoint dut (
      .clk(clk), .rst_n(rst_n),
      .high_write_data(wd), .high_write_addr(wa), .high_write_valid(wv),
      .high_read_data(rd), .high_read_valid(rv), .high_read_finish(fin),
      .fifo_count(cnt), .overflow(ovf), .addr_reject(arej)
   );

   high_bus_endpoint #(.ADDR_LO(16'h0100), .ADDR_HI(16'h01FF)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .high_write_data(wd), .high_write_addr(wa), .high_write_valid(wv_w),
      .high_read_data(rd_w), .high_read_valid(rv_w), .high_read_finish(fin),
      .fifo_count(cnt_w), .overflow(ovf_w), .addr_reject(arej_w)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wv = 1'b0; wv_w = 1'b0; fin = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // Bounded wait for read valid on the selected instance.
   task automatic wait_rv(input bit w, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if ((w ? rv_w : rv) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({rv, rd, cnt, ovf, arej} !== 38'd0)
         $display("FAIL reset_main: got %h want 0", {rv, rd, cnt, ovf, arej}); else passed++;
      checks++; if ({rv_w, rd_w, cnt_w, ovf_w, arej_w} !== 38'd0)
         $display("FAIL reset_win: got %h want 0", {rv_w, rd_w, cnt_w, ovf_w, arej_w}); else passed++;
   endtask

   task automatic test_single_word();
      do_reset();
      wd = 32'hA1B2C3D4; wa = 16'h0010; wv = 1'b1;
      tick();
      wv = 1'b0;
      checks++; if (rv !== 1'b0 || cnt !== 3'd1)
         $display("FAIL single_push: got rv=%b cnt=%0d want rv=0 cnt=1", rv, cnt); else passed++;
      tick();
      checks++; if (rv !== 1'b1 || rd !== 32'hA1B2C3D4 || cnt !== 3'd0)
         $display("FAIL single_pop: got rv=%b rd=%h cnt=%0d want rv=1 rd=a1b2c3d4 cnt=0", rv, rd, cnt); else passed++;
      fin = 1'b1;
      tick();
      fin = 1'b0;
      checks++; if (rv !== 1'b0 || cnt !== 3'd0)
         $display("FAIL single_finish: got rv=%b cnt=%0d want rv=0 cnt=0", rv, cnt); else passed++;
   endtask

   task automatic test_burst_slow_reader();
      bit ok;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         wd = 32'h11111111 * k; wa = 16'h0020; wv = 1'b1;
         tick();
      end
      wv = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         wait_rv(1'b0, ok);
         checks++; if (!ok || rd !== 32'h11111111 * k)
            $display("FAIL burst_word%0d: got ok=%b rd=%h want ok=1 rd=%h", k, ok, rd, 32'h11111111 * k); else passed++;
         tick(); tick(); tick();
         checks++; if (rv !== 1'b1 || rd !== 32'h11111111 * k)
            $display("FAIL burst_hold%0d: got rv=%b rd=%h want rv=1 rd=%h", k, rv, rd, 32'h11111111 * k); else passed++;
         fin = 1'b1;
         tick();
         fin = 1'b0;
         checks++; if (rv !== 1'b0)
            $display("FAIL burst_gap%0d: got rv=%b want 0", k, rv); else passed++;
      end
      checks++; if (ovf !== 1'b0 || cnt !== 3'd0)
         $display("FAIL burst_end: got ovf=%b cnt=%0d want ovf=0 cnt=0", ovf, cnt); else passed++;
   endtask

   task automatic test_overflow();
      bit ok;
      bit extra;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         wd = 32'hA0000000 + k; wa = 16'h0030; wv = 1'b1;
         tick();
      end
      wv = 1'b0;
      checks++; if (cnt !== 3'd4 || rv !== 1'b1 || rd !== 32'hA0000001 || ovf !== 1'b0)
         $display("FAIL ovf_fill: got cnt=%0d rv=%b rd=%h ovf=%b want cnt=4 rv=1 rd=a0000001 ovf=0", cnt, rv, rd, ovf); else passed++;
      wd = 32'hA0000006; wv = 1'b1;
      tick();
      wv = 1'b0;
      checks++; if (ovf !== 1'b1 || cnt !== 3'd4 || arej !== 1'b0)
         $display("FAIL ovf_sixth: got ovf=%b cnt=%0d arej=%b want ovf=1 cnt=4 arej=0", ovf, cnt, arej); else passed++;
      for (int k = 1; k <= 5; k++) begin
         wait_rv(1'b0, ok);
         checks++; if (!ok || rd !== 32'hA0000000 + k)
            $display("FAIL ovf_drain%0d: got ok=%b rd=%h want ok=1 rd=%h", k, ok, rd, 32'hA0000000 + k); else passed++;
         fin = 1'b1;
         tick();
         fin = 1'b0;
      end
      extra = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rv === 1'b1) extra = 1'b1;
         tick();
      end
      checks++; if (extra !== 1'b0 || cnt !== 3'd0 || ovf !== 1'b1)
         $display("FAIL ovf_after: got extra=%b cnt=%0d ovf=%b want extra=0 cnt=0 ovf=1", extra, cnt, ovf); else passed++;
   endtask

   task automatic test_addr_window();
      bit ok;
      bit extra;
      logic [15:0] addrs [4];
      logic [31:0] datas [4];
      addrs[0] = 16'h00FF; addrs[1] = 16'h0100; addrs[2] = 16'h01FF; addrs[3] = 16'h0200;
      datas[0] = 32'hBAD000FF; datas[1] = 32'hC0DE0100; datas[2] = 32'hC0DE01FF; datas[3] = 32'hBAD00200;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wa = addrs[k]; wd = datas[k]; wv_w = 1'b1;
         tick();
         if (k == 0) begin
            checks++; if (arej_w !== 1'b1 || cnt_w !== 3'd0)
               $display("FAIL win_low_reject: got arej=%b cnt=%0d want arej=1 cnt=0", arej_w, cnt_w); else passed++;
         end
      end
      wv_w = 1'b0;
      wait_rv(1'b1, ok);
      checks++; if (!ok || rd_w !== 32'hC0DE0100)
         $display("FAIL win_first: got ok=%b rd=%h want ok=1 rd=c0de0100", ok, rd_w); else passed++;
      fin = 1'b1; tick(); fin = 1'b0;
      wait_rv(1'b1, ok);
      checks++; if (!ok || rd_w !== 32'hC0DE01FF)
         $display("FAIL win_second: got ok=%b rd=%h want ok=1 rd=c0de01ff", ok, rd_w); else passed++;
      fin = 1'b1; tick(); fin = 1'b0;
      extra = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rv_w === 1'b1) extra = 1'b1;
         tick();
      end
      checks++; if (extra !== 1'b0 || arej_w !== 1'b1 || ovf_w !== 1'b0 || cnt_w !== 3'd0)
         $display("FAIL win_end: got extra=%b arej=%b ovf=%b cnt=%0d want 0 1 0 0", extra, arej_w, ovf_w, cnt_w); else passed++;
   endtask

   task automatic test_finish_held();
      int n;
      int idx [4];
      logic [31:0] got [4];
      do_reset();
      n = 0;
      fin = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i < 3) begin
            wd = 32'hF0000001 + i; wa = 16'h0040; wv = 1'b1;
         end else begin
            wv = 1'b0;
         end
         tick();
         if (rv === 1'b1 && n < 4) begin
            idx[n] = i; got[n] = rd; n++;
         end
      end
      fin = 1'b0;
      checks++; if (n !== 3)
         $display("FAIL held_count: got %0d words want 3", n); else passed++;
      if (n == 3) begin
         checks++; if (got[0] !== 32'hF0000001 || got[1] !== 32'hF0000002 || got[2] !== 32'hF0000003)
            $display("FAIL held_order: got %h %h %h want f0000001 f0000002 f0000003", got[0], got[1], got[2]); else passed++;
         checks++; if (idx[1] - idx[0] !== 3 || idx[2] - idx[1] !== 3)
            $display("FAIL held_spacing: got %0d %0d want 3 3", idx[1] - idx[0], idx[2] - idx[1]); else passed++;
      end
   endtask

   task automatic test_back_to_back_and_reset();
      bit seen;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         wd = 32'hB0000000 + k; wa = 16'h0050; wv = 1'b1;
         tick();
      end
      wv = 1'b0;
      fin = 1'b1; tick(); fin = 1'b0;
      tick();
      checks++; if (cnt !== 3'd2 || rv !== 1'b0)
         $display("FAIL same_edge_pre: got cnt=%0d rv=%b want cnt=2 rv=0", cnt, rv); else passed++;
      wd = 32'hB0000004; wv = 1'b1;
      tick();
      wv = 1'b0;
      checks++; if (cnt !== 3'd2 || rv !== 1'b1 || rd !== 32'hB0000002)
         $display("FAIL same_edge: got cnt=%0d rv=%b rd=%h want cnt=2 rv=1 rd=b0000002", cnt, rv, rd); else passed++;
      wd = 32'hB0000005; wv = 1'b1;
      tick();
      wv = 1'b0;
      checks++; if (cnt !== 3'd3 || rv !== 1'b1)
         $display("FAIL rst_setup: got cnt=%0d rv=%b want cnt=3 rv=1", cnt, rv); else passed++;
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({rv, rd, cnt} !== 36'd0)
         $display("FAIL async_reset: got rv=%b rd=%h cnt=%0d want all 0", rv, rd, cnt); else passed++;
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rv === 1'b1 || cnt !== 3'd0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0 || ovf !== 1'b0 || arej !== 1'b0)
         $display("FAIL post_reset: got stale=%b ovf=%b arej=%b want 0 0 0", seen, ovf, arej); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_burst_slow_reader();
      test_overflow();
      test_addr_window();
      test_finish_held();
      test_back_to_back_and_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
